// File: rtl/axi_read_sched.sv
// AXI read-address scheduler: round-robin arbitration between two masters,
// address decode to three slaves, single outstanding read with R-beat tracking.
module axi_read_sched #(
  parameter  int ID_BITS   = 4,
  parameter  int ADDR_BITS = 32,
  parameter  int LEN_BITS  = 4,
  parameter  int SIZE_BITS = 3,
  localparam int PKT       = ID_BITS + ADDR_BITS + LEN_BITS + SIZE_BITS + 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [PKT-1:0] M0_ARPkt,
  input  logic           M0_ARValid,
  output logic           M0_ARReady,
  input  logic [PKT-1:0] M1_ARPkt,
  input  logic           M1_ARValid,
  output logic           M1_ARReady,
  output logic [PKT-1:0] O_ARPkt,
  output logic           S0_ARValid,
  output logic           S1_ARValid,
  output logic           DS_ARValid,
  input  logic           S0_ARReady,
  input  logic           S1_ARReady,
  input  logic           DS_ARReady,
  input  logic           R_Hs,
  input  logic           R_Last,
  output logic           R_SelM,
  output logic [1:0]     R_SelS,
  output logic           Busy,
  output logic           Err_Len
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic [ADDR_BITS-1:0] S1_BASE = ADDR_BITS'(32'h0001_0000);
  localparam logic [ADDR_BITS-1:0] DS_BASE = ADDR_BITS'(32'h0002_0000);
  localparam int ADDR_LSB = LEN_BITS + SIZE_BITS + 2;
  localparam int LEN_LSB  = SIZE_BITS + 2;

  state_e              state_q;
  logic [PKT-1:0]      pkt_q;
  logic [2:0]          svalid_q;   // {DS, S1, S0}
  logic                selm_q;
  logic [1:0]          sels_q;
  logic                last_q;     // 1: M1 was granted last
  logic [LEN_BITS:0]   cnt_q;
  logic                err_q;

  logic                grant_m0;
  logic                grant_m1;
  logic                accept;
  logic [PKT-1:0]      win_pkt;
  logic [ADDR_BITS-1:0] win_addr;
  logic [1:0]          slv_d;
  logic                sel_ready;
  logic [LEN_BITS:0]   len_ext;

  // Round-robin grant and combinational accept; ready is suppressed while in reset.
  always_comb begin
    grant_m0   = M0_ARValid & (~M1_ARValid | last_q);
    grant_m1   = M1_ARValid & (~M0_ARValid | ~last_q);
    M0_ARReady = rst & (state_q == ST_IDLE) & grant_m0;
    M1_ARReady = rst & (state_q == ST_IDLE) & grant_m1;
    accept     = M0_ARReady | M1_ARReady;
    win_pkt    = grant_m1 ? M1_ARPkt : M0_ARPkt;
  end

  // Address decode of the winning request, registered alongside the payload.
  always_comb begin
    win_addr = win_pkt[ADDR_LSB +: ADDR_BITS];
    if (win_addr < S1_BASE) begin
      slv_d = 2'd0;
    end else if (win_addr < DS_BASE) begin
      slv_d = 2'd1;
    end else begin
      slv_d = 2'd2;
    end
  end

  // Ready of the selected slave only, and the latched burst length.
  always_comb begin
    case (sels_q)
      2'd0:    sel_ready = S0_ARReady;
      2'd1:    sel_ready = S1_ARReady;
      default: sel_ready = DS_ARReady;
    endcase
    len_ext = {1'b0, pkt_q[LEN_LSB +: LEN_BITS]};
  end

  // Transaction FSM: accept, hold address valid until slave ready, count R beats.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      pkt_q    <= '0;
      svalid_q <= '0;
      selm_q   <= 1'b0;
      sels_q   <= '0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            pkt_q    <= win_pkt;
            selm_q   <= grant_m1;
            last_q   <= grant_m1;
            sels_q   <= slv_d;
            svalid_q <= 3'b001 << slv_d;
            cnt_q    <= '0;
            state_q  <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (sel_ready) begin
            svalid_q <= '0;
            state_q  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (R_Hs) begin
            if (R_Last) begin
              if (cnt_q != len_ext) begin
                err_q <= 1'b1;
              end
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end else begin
              // Reaching LEN+1 beats without RLAST flags the error but keeps waiting.
              if (cnt_q == len_ext) begin
                err_q <= 1'b1;
              end
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign O_ARPkt    = pkt_q;
  assign S0_ARValid = svalid_q[0];
  assign S1_ARValid = svalid_q[1];
  assign DS_ARValid = svalid_q[2];
  assign R_SelM     = selm_q;
  assign R_SelS     = sels_q;
  assign Busy       = (state_q != ST_IDLE);
  assign Err_Len    = err_q;

endmodule

// File: doc/axi_read_sched.md
AXI_READ_SCHED -- requirements
Module: axi_read_sched

Interface
REQ-001 SHALL have parameters: ID_BITS, default 4, transaction ID width; ADDR_BITS, default 32, address width; LEN_BITS, default 4, burst length width; SIZE_BITS, default 3, burst size width.
REQ-002 SHALL define PKT = ID_BITS+ADDR_BITS+LEN_BITS+SIZE_BITS+2 (45 at defaults), packed {ID,ADDR,LEN,SIZE,BURST}, MSB first.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 M0_ARPkt  in  PKT  master 0 (IM fetch) AR payload.
REQ-006 M0_ARValid  in  1  master 0 request.
REQ-007 M0_ARReady  out  1  master 0 accept.
REQ-008 M1_ARPkt / M1_ARValid / M1_ARReady  in/in/out  PKT/1/1  master 1 (DM) equivalents.
REQ-009 O_ARPkt  out  PKT  registered payload broadcast to all slaves.
REQ-010 S0_ARValid, S1_ARValid, DS_ARValid  out  1 each  per-slave valid.
REQ-011 S0_ARReady, S1_ARReady, DS_ARReady  in  1 each  per-slave ready.
REQ-012 R_Hs  in  1  R-channel beat handshake (RVALID&RREADY) of the granted transaction.
REQ-013 R_Last  in  1  RLAST qualifying R_Hs.
REQ-014 R_SelM  out  1  owning master for R routing; R_SelS  out  2  owning slave (0=S0, 1=S1, 2=DS).
REQ-015 Busy  out  1  high when state is not IDLE; Err_Len  out  1  sticky burst-length mismatch flag.

Function
REQ-016 SHALL implement FSM IDLE -> ADDR -> DATA -> IDLE, one read transaction outstanding at a time.
REQ-017 IDLE: if any M*_ARValid, grant one master, assert its M*_ARReady combinationally that cycle, latch its payload into O_ARPkt, go ADDR; other M*_ARReady SHALL be 0.
REQ-018 Arbitration SHALL be round-robin: if both valid, grant the master not granted last; if one valid, grant it; last-grant pointer updates only on accept.
REQ-019 Decode on latched ADDR: 0x0000_0000-0x0000_FFFF -> S0; 0x0001_0000-0x0001_FFFF -> S1; all else -> DS; result registered with payload.
REQ-020 ADDR: exactly one of S0/S1/DS_ARValid high, per decode, from cycle after accept; O_ARPkt stable; valid SHALL NOT drop before the selected slave's ready.
REQ-021 ADDR: selected slave ready high -> DATA next cycle, valid low from that cycle; ready of non-selected slaves ignored.
REQ-022 DATA: beat counter starts at 0 and increments on each R_Hs; R_Hs with R_Last -> IDLE next cycle, counter cleared.
REQ-023 If R_Last arrives on beat count != LEN, or count reaches LEN+1 without R_Last, set Err_Len (held until reset); in the latter case keep waiting for R_Last.
REQ-024 R_Hs / R_Last outside DATA SHALL be ignored.
REQ-025 R_SelM / R_SelS SHALL be valid from ADDR entry until IDLE re-entry, holding the granted master/slave.
REQ-026 No accept in the cycle DATA exits; earliest new M*_ARReady is the first IDLE cycle (accept-to-accept minimum 3 cycles for a 1-beat burst with zero-wait slave).
REQ-027 Counter width SHALL be LEN_BITS+1 so LEN = all-ones does not wrap before detection.

Reset
REQ-028 On rst low, immediately: state IDLE, all *_ARReady and *_ARValid 0, O_ARPkt 0, R_SelM 0, R_SelS 0, Busy 0, Err_Len 0, beat counter 0, last-grant pointer = M1 (so M0 wins first tie).
REQ-029 Reset asserted mid-transaction SHALL abandon it with no further valid pulses; operation restarts in IDLE after rst deassert.

Verification
REQ-030 Both masters valid after reset, M0 ADDR 0x0000_0040 LEN 0, M1 ADDR 0x0001_0000 LEN 3 -> M0 granted first, S0_ARValid next cycle; after M0 R_Last, M1 granted, S1_ARValid, R_SelS=1.
REQ-031 M1 ADDR 0x0002_0000 -> DS_ARValid only; DS_ARReady after 4 wait cycles -> DS_ARValid held 4 cycles then drops, state DATA.
REQ-032 LEN 3, four R_Hs with R_Last on fourth -> IDLE, Err_Len 0; repeat with R_Last on second beat -> Err_Len 1 and sticks.
REQ-033 S1_ARReady pulsed while S0 selected -> ignored, S0_ARValid stays high.
REQ-034 rst low during DATA -> all outputs at reset values same cycle; new M0 request after release accepted in first IDLE cycle.
REQ-035 M0 valid continuously with M1 idle -> M0 granted every transaction; M1 valid added -> grants alternate M1, M0, M1.
